// File: rtl/bist_sequencer_if.sv
// TAP-side command/status bus for bist_sequencer.
//
// Signals:
//   cmd_valid : one-cycle pulse, cmd holds a new Update-DR word
//   cmd       : [15:12] opcode, [11:0] argument
//   status    : {busy, done, pass, abort_flag, sig[11:0]}, captured on Capture-DR
//   sig       : full current MISR value
//
// Modports:
//   master : TAP side (drives cmd_valid/cmd, observes status/sig)
//   slave  : sequencer side
interface bist_sequencer_if #(
    parameter int unsigned SIG_W = 16
);
    logic             cmd_valid;
    logic [15:0]      cmd;
    logic [15:0]      status;
    logic [SIG_W-1:0] sig;

    modport master (
        output cmd_valid,
        output cmd,
        input  status,
        input  sig
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        output status,
        output sig
    );
endinterface

// File: rtl/bist_sequencer.sv
// BIST sequencer for the unit-under-logic (UUL) behind the JTAG TAP.
//
// A start command (opcode 0x3, N = cmd[11:0], 0 meaning 4096) applies N LFSR
// patterns to the UUL parallel input, compacts the UUL response in a MISR,
// then compares the signature against GOLDEN_SIG. Opcode 0x4 clears done/pass
// and reseeds the MISR. Commands arriving while busy are ignored.
//
// Optional feature, macro BIST_ABORT_EN: opcode 0x5 while running returns to
// idle immediately, freezes the MISR and sets status[12] (abort_flag) until
// the next 0x3 or 0x4. Without the macro 0x5 is ignored and status[12] is 0.
//
// Ports:
//   clk_50MHz : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : command/status interface (slave modport)
//   uul_pout  : UUL parallel output (MISR input)
//   func_pin  : functional parallel input, forwarded when not under test
//   uul_pin   : UUL parallel input, LFSR pattern while bist_sel=1
//   bist_sel  : high while the UUL is under test
module bist_sequencer #(
    parameter int unsigned      PIN_W      = 6,
    parameter int unsigned      POUT_W     = 4,
    parameter int unsigned      SIG_W      = 16,
    parameter logic [PIN_W-1:0] LFSR_SEED  = PIN_W'(6'h01),
    parameter logic [SIG_W-1:0] MISR_SEED  = SIG_W'(16'hFFFF),
    parameter logic [SIG_W-1:0] GOLDEN_SIG = SIG_W'(16'h0000),
    parameter int unsigned      UUL_LAT    = 1
) (
    input  logic              clk_50MHz,
    input  logic              rst_n,
    bist_sequencer_if.slave   bus,
    input  logic [POUT_W-1:0] uul_pout,
    input  logic [PIN_W-1:0]  func_pin,
    output logic [PIN_W-1:0]  uul_pin,
    output logic              bist_sel
);

    localparam logic [3:0] OP_START = 4'h3;
    localparam logic [3:0] OP_CLEAR = 4'h4;
    localparam logic [3:0] OP_ABORT = 4'h5;
    localparam logic [2:0] LAT_SEL  = 3'(UUL_LAT);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StCompare} state_e;

    state_e           state_q;
    logic [PIN_W-1:0] lfsr_q;
    logic [SIG_W-1:0] misr_q;
    logic [12:0]      cnt_q;
    logic [2:0]       fcnt_q;
    logic [6:0]       pipe_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic [3:0]       op;
    logic [12:0]      n_start;
    logic [PIN_W-1:0] lfsr_next;
    logic [SIG_W-1:0] misr_next;
    logic [7:0]       tap;
    logic             running;
    logic             misr_en;
    logic             abort_req;
    logic             abort_bit;

    assign op      = bus.cmd[15:12];
    assign n_start = (bus.cmd[11:0] == 12'd0) ? 13'd4096 : {1'b0, bus.cmd[11:0]};

    assign lfsr_next = {lfsr_q[PIN_W-2:0], lfsr_q[PIN_W-1] ^ lfsr_q[PIN_W-2]};
    assign misr_next = {misr_q[SIG_W-2:0], 1'b0}
                     ^ (misr_q[SIG_W-1] ? SIG_W'(16'h1021) : '0)
                     ^ SIG_W'(uul_pout);

    assign running = (state_q == StRun) || (state_q == StFlush);

`ifdef BIST_ABORT_EN
    logic abort_q;
    assign abort_req = running && bus.cmd_valid && (op == OP_ABORT);
    assign abort_bit = abort_q;
`else
    assign abort_req = 1'b0;
    assign abort_bit = 1'b0;
`endif

    // tap[k] is "a pattern was applied k cycles ago"; the MISR samples the UUL
    // response UUL_LAT cycles after each applied pattern.
    assign tap     = {pipe_q, state_q == StRun};
    assign misr_en = tap[LAT_SEL] && running && !abort_req;

    assign uul_pin    = bist_sel ? lfsr_q : func_pin;
    assign bus.sig    = misr_q;
    assign bus.status = {busy_q, done_q, pass_q, abort_bit, misr_q[11:0]};

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            lfsr_q   <= LFSR_SEED;
            misr_q   <= MISR_SEED;
            cnt_q    <= '0;
            fcnt_q   <= '0;
            pipe_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            bist_sel <= 1'b0;
`ifdef BIST_ABORT_EN
            abort_q  <= 1'b0;
`endif
        end else begin
            pipe_q <= tap[6:0];
            if (misr_en) begin
                misr_q <= misr_next;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid && op == OP_START) begin
                        state_q  <= StRun;
                        lfsr_q   <= LFSR_SEED;
                        misr_q   <= MISR_SEED;
                        cnt_q    <= n_start;
                        pipe_q   <= '0;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        bist_sel <= 1'b1;
`ifdef BIST_ABORT_EN
                        abort_q  <= 1'b0;
`endif
                    end else if (bus.cmd_valid && op == OP_CLEAR) begin
                        done_q <= 1'b0;
                        pass_q <= 1'b0;
                        misr_q <= MISR_SEED;
`ifdef BIST_ABORT_EN
                        abort_q <= 1'b0;
`endif
                    end
                end

                StRun: begin
                    if (abort_req) begin
                        state_q  <= StIdle;
                        busy_q   <= 1'b0;
                        bist_sel <= 1'b0;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                        pipe_q   <= '0;
`ifdef BIST_ABORT_EN
                        abort_q  <= 1'b1;
`endif
                    end else if (cnt_q == 13'd1) begin
                        // Last pattern: LFSR holds so uul_pin keeps it during flush.
                        if (UUL_LAT == 0) begin
                            state_q <= StCompare;
                        end else begin
                            state_q <= StFlush;
                            fcnt_q  <= LAT_SEL;
                        end
                    end else begin
                        lfsr_q <= lfsr_next;
                        cnt_q  <= cnt_q - 13'd1;
                    end
                end

                StFlush: begin
                    if (abort_req) begin
                        state_q  <= StIdle;
                        busy_q   <= 1'b0;
                        bist_sel <= 1'b0;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                        pipe_q   <= '0;
`ifdef BIST_ABORT_EN
                        abort_q  <= 1'b1;
`endif
                    end else if (fcnt_q == 3'd1) begin
                        state_q <= StCompare;
                    end else begin
                        fcnt_q <= fcnt_q - 3'd1;
                    end
                end

                StCompare: begin
                    pass_q   <= (misr_q == GOLDEN_SIG);
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    bist_sel <= 1'b0;
                    state_q  <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_sequencer.sv
module tb_bist_sequencer;

    localparam int          LAT    = 1;
    localparam logic [15:0] GOLDEN = 16'h0000;
`ifdef BIST_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [3:0] uul_pout = 4'h0;
    logic [5:0] func_pin = 6'h00;
    logic [5:0] uul_pin;
    logic       bist_sel;

    always #10 clk = ~clk;

    bist_sequencer_if #(.SIG_W(16)) bus ();

    bist_sequencer #(
        .PIN_W      (6),
        .POUT_W     (4),
        .SIG_W      (16),
        .LFSR_SEED  (6'h01),
        .MISR_SEED  (16'hFFFF),
        .GOLDEN_SIG (GOLDEN),
        .UUL_LAT    (LAT)
    ) dut (
        .clk_50MHz (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .uul_pout  (uul_pout),
        .func_pin  (func_pin),
        .uul_pin   (uul_pin),
        .bist_sel  (bist_sel)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: a run is "k cycles since the first pattern" out of N.
    bit          m_active = 1'b0;
    int          m_k      = 0;
    int          m_n      = 0;
    bit          m_done   = 1'b0;
    bit          m_pass   = 1'b0;
    bit          m_abort  = 1'b0;
    logic [15:0] m_sig    = 16'hFFFF;

    logic [5:0] pat      [4096];
    logic [3:0] pout_seq [4096];
    int         flip_idx = -1;

    function automatic logic [15:0] misr_f(input logic [15:0] m, input logic [3:0] p);
        return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {12'h000, p};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_pass   = 1'b0;
            m_abort  = 1'b0;
            m_sig    = 16'hFFFF;
        end else if (m_active) begin
            if (ABORT_EN && bus.cmd_valid && bus.cmd[15:12] == 4'h5 && m_k < m_n + LAT) begin
                m_active = 1'b0;
                m_done   = 1'b0;
                m_pass   = 1'b0;
                m_abort  = 1'b1;
            end else if (m_k == m_n + LAT) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                m_pass   = (m_sig == GOLDEN);
            end else begin
                if (m_k >= LAT) m_sig = misr_f(m_sig, uul_pout);
                m_k++;
            end
        end else if (bus.cmd_valid && bus.cmd[15:12] == 4'h3) begin
            m_active = 1'b1;
            m_k      = 0;
            m_n      = (bus.cmd[11:0] == 12'd0) ? 4096 : int'(bus.cmd[11:0]);
            m_sig    = 16'hFFFF;
            m_done   = 1'b0;
            m_pass   = 1'b0;
            m_abort  = 1'b0;
        end else if (bus.cmd_valid && bus.cmd[15:12] == 4'h4) begin
            m_sig   = 16'hFFFF;
            m_done  = 1'b0;
            m_pass  = 1'b0;
            m_abort = 1'b0;
        end
    end

    // Every-cycle compare, away from the active edge.
    always @(negedge clk) begin
        logic [5:0] e_pin;
        int         idx;
        idx   = (m_k < m_n) ? m_k : m_n - 1;
        e_pin = m_active ? pat[idx] : func_pin;
        chk("bist_sel", 16'(bist_sel), 16'(m_active));
        chk("uul_pin", 16'(uul_pin), 16'(e_pin));
        chk("status", bus.status, {m_active, m_done, m_pass, m_abort, m_sig[11:0]});
        chk("sig", bus.sig, m_sig);
    end

    function automatic logic [3:0] pout_now();
        logic [3:0] v;
        int         idx;
        if (m_active && m_k >= LAT && m_k < m_n + LAT) begin
            idx = m_k - LAT;
            v   = pout_seq[idx];
            if (idx == flip_idx) v = v ^ 4'b0100;
        end else begin
            v = 4'($urandom);
        end
        return v;
    endfunction

    task automatic step(input logic cv, input logic [15:0] c);
        bus.cmd_valid = cv;
        bus.cmd       = c;
        func_pin      = 6'($urandom);
        uul_pout      = pout_now();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (!bus.status[14] && cyc < limit) begin
            step(1'b0, 16'h0000);
            cyc++;
        end
        if (!bus.status[14]) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: done still %b after %0d cycles", bus.status[14], cyc);
        end
    endtask

    // Random responses; optionally make the last 16 samples drive the signature to 0.
    // Each of the final 16 bit-0 inputs lands on a distinct signature bit.
    task automatic prep_seq(input int n, input bit force_zero);
        logic [15:0] s;
        for (int i = 0; i < 4096; i++) pout_seq[i] = 4'($urandom);
        if (force_zero) begin
            s = 16'hFFFF;
            for (int i = 0; i < n - 16; i++) s = misr_f(s, pout_seq[i]);
            for (int i = 0; i < 16; i++) s = misr_f(s, 4'h0);
            for (int i = 0; i < 16; i++) pout_seq[n - 16 + i] = {3'b000, s[15 - i]};
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] l;
        logic [5:0] lit [6];
        int         c;

        bus.cmd_valid = 1'b0;
        bus.cmd       = 16'h0000;
        l = 6'h01;
        for (int i = 0; i < 4096; i++) begin
            pat[i] = l;
            l = {l[4:0], l[5] ^ l[4]};
        end
        lit[0] = 6'h01; lit[1] = 6'h02; lit[2] = 6'h04;
        lit[3] = 6'h08; lit[4] = 6'h10; lit[5] = 6'h21;
        chk("model_pat5", 16'(pat[5]), 16'(lit[5]));

        @(negedge clk);
        #1;
        repeat (3) step(1'b0, 16'h0000);
        chk("rst_bist_sel", 16'(bist_sel), 16'h0000);
        chk("rst_status", bus.status, 16'h0FFF);
        chk("rst_sig", bus.sig, 16'hFFFF);
        chk("rst_uul_pin", 16'(uul_pin), 16'(func_pin));
        rst_n = 1'b1;
        step(1'b0, 16'h0000);

        // Six patterns, LFSR sequence and done latency.
        prep_seq(6, 1'b0);
        step(1'b1, 16'h3006);
        for (int i = 0; i < 8; i++) begin
            chk("n6_done_low", 16'(bus.status[14]), 16'h0000);
            if (i < 6) chk("n6_pattern", 16'(uul_pin), 16'(lit[i]));
            step(1'b0, 16'h0000);
        end
        chk("n6_done", 16'(bus.status[15:13]), 16'h0002);

        // Second start during a run is ignored.
        prep_seq(16, 1'b0);
        step(1'b1, 16'h3010);
        repeat (4) step(1'b0, 16'h0000);
        step(1'b1, 16'h3002);
        wait_done(100, c);
        chk("n16_latency", 16'(c + 5), 16'd18);

        // 4096 patterns, signature steered to GOLDEN.
        flip_idx = -1;
        prep_seq(4096, 1'b1);
        step(1'b1, 16'h3000);
        wait_done(5000, c);
        chk("n4096_latency", 16'(c), 16'd4098);
        chk("n4096_model_sig", m_sig, 16'h0000);
        chk("n4096_pass", 16'(bus.status[15:13]), 16'h0003);
        chk("n4096_sig", bus.sig, 16'h0000);

        // Same responses with one bit flipped once.
        flip_idx = 1234;
        step(1'b1, 16'h3000);
        wait_done(5000, c);
        flip_idx = -1;
        chk("flip_model_pass", 16'(m_pass), 16'h0000);
        chk("flip_fail", 16'(bus.status[15:13]), 16'h0002);

        // Unknown opcode leaves sticky flags alone; clear resets them.
        step(1'b1, 16'h7123);
        chk("unk_done_kept", 16'(bus.status[14]), 16'h0001);
        step(1'b1, 16'h4000);
        chk("clear_status", bus.status, 16'h0FFF);
        chk("clear_sig", bus.sig, 16'hFFFF);
        step(1'b1, 16'h7123);
        chk("unk_idle_status", bus.status, 16'h0FFF);

        // Abort opcode at pattern 20.
        prep_seq(256, 1'b0);
        step(1'b1, 16'h3100);
        repeat (20) step(1'b0, 16'h0000);
        step(1'b1, 16'h5000);
`ifdef BIST_ABORT_EN
        chk("abort_flags", 16'(bus.status[15:12]), 16'h0001);
        chk("abort_bist_sel", 16'(bist_sel), 16'h0000);
        repeat (3) step(1'b0, 16'h0000);
        step(1'b1, 16'h4000);
        chk("abort_cleared", 16'(bus.status[12]), 16'h0000);
`else
        chk("noabort_busy", 16'(bus.status[15]), 16'h0001);
        wait_done(400, c);
        chk("noabort_latency", 16'(c + 21), 16'd258);
        chk("noabort_done", 16'(bus.status[14]), 16'h0001);
`endif

        // Reset in the middle of a run.
        prep_seq(100, 1'b0);
        step(1'b1, 16'h3064);
        repeat (40) step(1'b0, 16'h0000);
        rst_n = 1'b0;
        step(1'b0, 16'h0000);
        chk("midrst_bist_sel", 16'(bist_sel), 16'h0000);
        chk("midrst_flags", 16'(bus.status[15:13]), 16'h0000);
        chk("midrst_sig", bus.sig, 16'hFFFF);
        chk("midrst_uul_pin", 16'(uul_pin), 16'(func_pin));
        rst_n = 1'b1;
        repeat (3) step(1'b0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
